// File: rtl/dp_ram_mailbox_pkg.sv
// Shared constants for the dual-port RAM mailbox: IO register map,
// CTRL/STATUS bit positions and the mailbox FSM encoding.
package dp_ram_mailbox_pkg;

  // Register addresses on the J1 IO bus (8 LSB of the IO address)
  localparam logic [7:0] REG_CTRL   = 8'h80;
  localparam logic [7:0] REG_STATUS = 8'h81;
  localparam logic [7:0] REG_PTR    = 8'h82;
  localparam logic [7:0] REG_DATA   = 8'h83;
  localparam logic [7:0] REG_LEN    = 8'h84;

  // CTRL bits: go/clr/abort are self-clearing commands, ie is stored
  localparam int CTRL_GO    = 0;
  localparam int CTRL_CLR   = 1;
  localparam int CTRL_ABORT = 2;
  localparam int CTRL_IE    = 3;

  // STATUS bits: coll and err are sticky, write-1-to-clear
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_COLL = 2;
  localparam int STAT_ERR  = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/dp_ram_mailbox_core.sv
// True dual-port synchronous RAM, read-first on both ports.
// Contents and output registers carry no reset.
module dp_ram_core #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              a_en_i,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_din_i,
  output logic [DATA_W-1:0] a_dout_o,
  input  logic              b_en_i,
  input  logic              b_we_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_din_i,
  output logic [DATA_W-1:0] b_dout_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] a_dout_q;
  logic [DATA_W-1:0] b_dout_q;

  // Both ports in one process so the array has a single writer; the port B
  // write is issued last and therefore wins a same-address write.
  // NOTE: the memory array is deliberately left out of reset so it maps onto
  // block RAM; resetting it would force a flop array.
  always_ff @(posedge clk) begin
    if (a_en_i) begin
      if (a_we_i) mem_q[a_addr_i] <= a_din_i;
      a_dout_q <= mem_q[a_addr_i];
    end
    if (b_en_i) begin
      if (b_we_i) mem_q[b_addr_i] <= b_din_i;
      b_dout_q <= mem_q[b_addr_i];
    end
  end

  assign a_dout_o = a_dout_q;
  assign b_dout_o = b_dout_q;

endmodule

// File: rtl/dp_ram_mailbox.sv
// J1 IO-mapped dual-port RAM with pointer/auto-increment access and a
// go/done mailbox that hands the RAM block to a hardware engine.
module dp_ram_mailbox
  import dp_ram_mailbox_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 6,
  parameter int IO_ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cs,
  input  logic                 rd,
  input  logic                 wr,
  input  logic [IO_ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0]    d_in,
  output logic [DATA_W-1:0]    d_out,
  input  logic                 b_en,
  input  logic                 b_we,
  input  logic [ADDR_W-1:0]    b_addr,
  input  logic [DATA_W-1:0]    b_din,
  output logic [DATA_W-1:0]    b_dout,
  output logic                 b_start,
  output logic [ADDR_W:0]      b_len,
  output logic                 b_abort,
  input  logic                 b_done,
  output logic                 irq
);

  // ---------------------------------------------------------------- decode
  logic [7:0] io_addr;
  logic       a_wr, a_rd;
  logic       sel_win, sel_ctrl, sel_status, sel_ptr, sel_data, sel_len;
  logic       sel_ram;

  assign io_addr    = addr[7:0];
  assign a_wr       = cs & wr;
  assign a_rd       = cs & rd & ~wr;
  assign sel_win    = ~io_addr[7];
  assign sel_ctrl   = (io_addr == REG_CTRL);
  assign sel_status = (io_addr == REG_STATUS);
  assign sel_ptr    = (io_addr == REG_PTR);
  assign sel_data   = (io_addr == REG_DATA);
  assign sel_len    = (io_addr == REG_LEN);
  assign sel_ram    = sel_win | sel_data;

  // ---------------------------------------------------------------- state
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   b_len_q, b_len_d;
  logic              ie_q, ie_d;
  logic              coll_q, coll_d;
  logic              err_q, err_d;
  logic              b_start_q, b_start_d;
  logic              b_abort_q, b_abort_d;
  logic              busy, done;

  logic cmd_go, cmd_clr, cmd_abort;
  assign cmd_go    = a_wr & sel_ctrl & d_in[CTRL_GO];
  assign cmd_clr   = a_wr & sel_ctrl & d_in[CTRL_CLR];
  assign cmd_abort = a_wr & sel_ctrl & d_in[CTRL_ABORT];

  // ---------------------------------------------------------------- port A RAM access
  logic [ADDR_W-1:0] a_ram_addr;
  logic              a_wr_req, a_wr_ok, a_wr_blocked, coll_hit;
  logic              a_ram_en, a_ram_we;
  logic [DATA_W-1:0] a_ram_dout, b_ram_dout;

  assign a_ram_addr   = sel_win ? addr[ADDR_W-1:0] : ptr_q;
  assign a_wr_req     = a_wr & sel_ram;
  assign a_wr_blocked = a_wr_req & busy;
  assign a_wr_ok      = a_wr_req & ~busy;
  // Port B owns the cell when both ports write the same address.
  assign coll_hit     = a_wr_ok & b_en & b_we & (b_addr == a_ram_addr);
  assign a_ram_we     = a_wr_ok & ~coll_hit;
  assign a_ram_en     = a_ram_we | (a_rd & sel_ram);

  dp_ram_core #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_core (
    .clk     (clk),
    .a_en_i  (a_ram_en),
    .a_we_i  (a_ram_we),
    .a_addr_i(a_ram_addr),
    .a_din_i (d_in),
    .a_dout_o(a_ram_dout),
    .b_en_i  (b_en),
    .b_we_i  (b_en & b_we),
    .b_addr_i(b_addr),
    .b_din_i (b_din),
    .b_dout_o(b_ram_dout)
  );

  // Next values of the CPU-visible registers and sticky flags
  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    ptr_d  = ptr_q;
    len_d  = len_q;
    ie_d   = ie_q;
    coll_d = coll_q;
    err_d  = err_q;
    if (a_wr & sel_ptr) ptr_d = d_in[ADDR_W-1:0];
    else if (sel_data & (a_rd | a_wr_ok)) ptr_d = ptr_q + 1'b1;
    if (a_wr & sel_len)  len_d = d_in[ADDR_W:0];
    if (a_wr & sel_ctrl) ie_d  = d_in[CTRL_IE];
    // Clear first so a fresh event in the same cycle is not lost.
    if (a_wr & sel_status & d_in[STAT_COLL]) coll_d = 1'b0;
    if (a_wr & sel_status & d_in[STAT_ERR])  err_d  = 1'b0;
    if (coll_hit) coll_d = 1'b1;
    if (a_wr_blocked || (cmd_go && state_q != S_IDLE)) err_d = 1'b1;
  end

  // Register storage
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge value of its inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      len_q  <= '0;
      ie_q   <= 1'b0;
      coll_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      len_q  <= len_d;
      ie_q   <= ie_d;
      coll_q <= coll_d;
      err_q  <= err_d;
    end
  end

  // ---------------------------------------------------------------- mailbox FSM
  // FSM state register with its registered one-cycle strobes and job length
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      b_start_q <= 1'b0;
      b_abort_q <= 1'b0;
      b_len_q   <= '0;
    end else begin
      state_q   <= state_d;
      b_start_q <= b_start_d;
      b_abort_q <= b_abort_d;
      b_len_q   <= b_len_d;
    end
  end

  // FSM next state; abort beats a simultaneous b_done
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_go) state_d = S_BUSY;
      S_BUSY: begin
        if (cmd_abort)   state_d = S_IDLE;
        else if (b_done) state_d = S_DONE;
      end
      S_DONE:  if (cmd_clr) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: status levels and next values of the engine strobes
  always_comb begin
    busy      = (state_q == S_BUSY);
    done      = (state_q == S_DONE);
    b_start_d = (state_q == S_IDLE) & cmd_go;
    b_abort_d = (state_q == S_BUSY) & cmd_abort;
    b_len_d   = b_start_d ? len_q : b_len_q;
  end

  // ---------------------------------------------------------------- port A read pipeline
  logic [DATA_W-1:0] reg_rdata, reg_rdata_q, d_out_q;
  logic              rd_pend_q, rd_ram_q;

  // Register read mux; unmapped addresses read zero
  always_comb begin
    reg_rdata = '0;
    if (sel_ctrl) reg_rdata[CTRL_IE] = ie_q;
    if (sel_status) begin
      reg_rdata[STAT_BUSY] = busy;
      reg_rdata[STAT_DONE] = done;
      reg_rdata[STAT_COLL] = coll_q;
      reg_rdata[STAT_ERR]  = err_q;
    end
    if (sel_ptr) reg_rdata[ADDR_W-1:0] = ptr_q;
    if (sel_len) reg_rdata[ADDR_W:0]   = len_q;
  end

  // Capture the read at the strobe edge, present it on d_out one edge later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_q   <= 1'b0;
      rd_ram_q    <= 1'b0;
      reg_rdata_q <= '0;
      d_out_q     <= '0;
    end else begin
      rd_pend_q <= a_rd;
      if (a_rd) begin
        rd_ram_q    <= sel_ram;
        reg_rdata_q <= reg_rdata;
      end
      if (rd_pend_q) d_out_q <= rd_ram_q ? a_ram_dout : reg_rdata_q;
    end
  end

  // ---------------------------------------------------------------- port B output
  logic b_vld_q;

  // Mask the unreset RAM output register until port B has read once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    b_vld_q <= 1'b0;
    else if (b_en) b_vld_q <= 1'b1;
  end

  assign d_out   = d_out_q;
  assign b_dout  = b_vld_q ? b_ram_dout : '0;
  assign b_start = b_start_q;
  assign b_abort = b_abort_q;
  assign b_len   = b_len_q;
  assign irq     = done & ie_q;

endmodule

// File: tb/tb_dp_ram_mailbox.sv
// Self-checking bench for dp_ram_mailbox with scoreboard queues for the
// port A and port B read paths.
module tb_dp_ram_mailbox;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cs, rd, wr;
  logic [7:0]        addr;
  logic [DATA_W-1:0] d_in, d_out;
  logic              b_en, b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_din, b_dout;
  logic              b_start, b_abort, b_done, irq;
  logic [ADDR_W:0]   b_len;

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] exp_a_q [$];
  logic [DATA_W-1:0] exp_b_q [$];

  dp_ram_mailbox #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IO_ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .rd(rd), .wr(wr), .addr(addr),
    .d_in(d_in), .d_out(d_out), .b_en(b_en), .b_we(b_we), .b_addr(b_addr),
    .b_din(b_din), .b_dout(b_dout), .b_start(b_start), .b_len(b_len),
    .b_abort(b_abort), .b_done(b_done), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge so the DUT samples them on the rising edge.
  task automatic a_write(input logic [7:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic a_read(input string tag, input logic [7:0] a, input logic [DATA_W-1:0] exp);
    exp_a_q.push_back(exp);
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
    @(negedge clk);
    check(tag, d_out, exp_a_q.pop_front());
  endtask

  task automatic b_access(input string tag, input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] exp);
    exp_b_q.push_back(exp);
    @(negedge clk);
    b_en = 1'b1; b_we = we; b_addr = a; b_din = d;
    @(negedge clk);
    b_en = 1'b0; b_we = 1'b0;
    check(tag, b_dout, exp_b_q.pop_front());
  endtask

  task automatic go_job(input logic [ADDR_W:0] len);
    a_write(8'h84, DATA_W'(len));
    a_write(8'h80, 16'h0009);
    check("b_start_pulse", b_start, 1);
    check("b_len", b_len, len);
  endtask

  initial begin
    rst_n = 1'b0; cs = 0; rd = 0; wr = 0; addr = 0; d_in = 0;
    b_en = 0; b_we = 0; b_addr = 0; b_din = 0; b_done = 0;
    #12;
    check("rst_d_out", d_out, 0);
    check("rst_b_dout", b_dout, 0);
    check("rst_irq", irq, 0);
    check("rst_b_start", b_start, 0);
    check("rst_b_abort", b_abort, 0);
    check("rst_b_len", b_len, 0);
    @(negedge clk);
    rst_n = 1'b1;
    a_read("rst_status", 8'h81, 16'h0000);

    // RAM window write/read and overwrite
    a_write(8'h30, 16'h000C);
    a_read("win_rd1", 8'h30, 16'h000C);
    a_write(8'h30, 16'h000B);
    a_read("win_rd2", 8'h30, 16'h000B);
    a_read("unmapped_rd", 8'h87, 16'h0000);

    // Auto-increment wraps from DEPTH-1 to 0
    a_write(8'h82, 16'h003F);
    a_write(8'h83, 16'h1111);
    a_write(8'h83, 16'h2222);
    a_read("ptr_wrap", 8'h82, 16'h0001);
    a_read("ram_3f", 8'h3F, 16'h1111);
    a_read("ram_00", 8'h00, 16'h2222);
    a_read("ptr_after_win", 8'h82, 16'h0001);

    // Mailbox go / done / clr
    go_job(7'd5);
    @(negedge clk);
    check("b_start_single", b_start, 0);
    a_read("status_busy", 8'h81, 16'h0001);
    a_read("ctrl_ie", 8'h80, 16'h0008);
    @(negedge clk); b_done = 1'b1;
    @(negedge clk); b_done = 1'b0;
    check("irq_done", irq, 1);
    a_read("status_done", 8'h81, 16'h0002);
    a_write(8'h80, 16'h000A);
    check("irq_clr", irq, 0);
    a_read("status_clr", 8'h81, 16'h0000);

    // Protection while BUSY
    a_write(8'h05, 16'h0055);
    go_job(7'd3);
    a_write(8'h05, 16'h1234);
    a_read("prot_ram", 8'h05, 16'h0055);
    a_read("prot_status", 8'h81, 16'h0009);
    a_write(8'h82, 16'h0005);
    a_write(8'h83, 16'hBEEF);
    a_read("prot_ptr", 8'h82, 16'h0005);
    a_write(8'h80, 16'h0009);
    check("go_again_no_start", b_start, 0);
    a_read("go_again_status", 8'h81, 16'h0009);
    a_write(8'h81, 16'h0008);
    a_read("err_clr", 8'h81, 16'h0001);

    // Abort beats b_done in the same cycle
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; addr = 8'h80; d_in = 16'h000C; b_done = 1'b1;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0; b_done = 1'b0;
    check("b_abort_pulse", b_abort, 1);
    check("abort_irq", irq, 0);
    @(negedge clk);
    check("b_abort_single", b_abort, 0);
    a_read("abort_status", 8'h81, 16'h0000);

    // Same-cycle, same-address write collision: port B wins
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; addr = 8'h10; d_in = 16'hAAAA;
    b_en = 1'b1; b_we = 1'b1; b_addr = 6'h10; b_din = 16'h5555;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0; b_en = 1'b0; b_we = 1'b0;
    a_read("coll_ram", 8'h10, 16'h5555);
    a_read("coll_status", 8'h81, 16'h0004);
    b_access("b_rd_coll", 1'b0, 6'h10, 16'h0000, 16'h5555);
    b_access("b_read_first", 1'b1, 6'h10, 16'h7777, 16'h5555);
    b_access("b_rd_new", 1'b0, 6'h10, 16'h0000, 16'h7777);
    @(negedge clk);
    check("b_dout_hold", b_dout, 16'h7777);
    a_write(8'h81, 16'h0004);
    a_read("coll_clr", 8'h81, 16'h0000);

    // Asynchronous reset in the middle of a job
    a_read("pre_rst_rd", 8'h30, 16'h000B);
    go_job(7'd7);
    #2 rst_n = 1'b0;
    #1;
    check("arst_b_start", b_start, 0);
    check("arst_b_len", b_len, 0);
    check("arst_d_out", d_out, 0);
    check("arst_b_dout", b_dout, 0);
    check("arst_irq", irq, 0);
    @(negedge clk);
    rst_n = 1'b1;
    a_read("post_rst_status", 8'h81, 16'h0000);
    a_read("post_rst_ram", 8'h30, 16'h000B);
    a_read("post_rst_ptr", 8'h82, 16'h0000);
    a_read("post_rst_len", 8'h84, 16'h0000);

    check("sb_a_empty", exp_a_q.size(), 0);
    check("sb_b_empty", exp_b_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
